// File: rtl/vec_wb_collector_if.sv
// Register-file write port driven by vec_wb_collector: indexed element writes with a ready
// handshake. The collector is the master; the register file is the slave.
interface vec_wb_collector_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VW         = 6,
  parameter int unsigned REG_BITS   = 5
) ();
  logic                  we_o;
  logic [REG_BITS-1:0]   wreg_o;
  logic [VW-1:0]         widx_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  wr_ready_i;

  modport master (
    output we_o,
    output wreg_o,
    output widx_o,
    output wdata_o,
    input  wr_ready_i
  );

  modport slave (
    input  we_o,
    input  wreg_o,
    input  widx_o,
    input  wdata_o,
    output wr_ready_i
  );
endinterface

// File: rtl/vec_wb_collector.sv
// Vector write-back collector: counts masked result elements into a small FIFO feeding one VRF
// write port. Define VWB_MASK_ZERO_EN to write masked-off elements as zero instead of dropping.
module vec_wb_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MVL        = 32,
  parameter int unsigned ID         = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REG_BITS   = 5,
  localparam int unsigned VW        = ((MVL <= 1) ? 1 : $clog2(MVL)) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VW-1:0]         vlr_i,
  input  logic [REG_BITS-1:0]   vd_i,
  input  logic [DATA_WIDTH+1:0] result_i,
  vec_wb_collector_if.master    wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7:0]            id_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = VW + DATA_WIDTH;

`ifdef VWB_MASK_ZERO_EN
  localparam bit MaskZeroEn = 1'b1;
`else
  localparam bit MaskZeroEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                state_q, state_d;
  logic [VW-1:0]         vlr_q, vlr_d;
  logic [VW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [REG_BITS-1:0]   vd_q, vd_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];

  logic                  res_valid, res_mask;
  logic [DATA_WIDTH-1:0] res_data, push_data;
  logic                  fifo_empty, fifo_full;
  logic                  elem_in, push_req, push, pop, lost;

  assign res_valid = result_i[DATA_WIDTH+1];
  assign res_mask  = result_i[DATA_WIDTH];
  assign res_data  = result_i[DATA_WIDTH-1:0];
  assign push_data = res_mask ? res_data : '0;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop      = !fifo_empty && wr.wr_ready_i;
  assign elem_in  = (state_q == StCollect) && res_valid;
  assign push_req = elem_in && (res_mask || MaskZeroEn);
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push     = push_req && (!fifo_full || pop);
  assign lost     = push_req && fifo_full && !pop;

  always_comb begin
    state_d  = state_q;
    vlr_d    = vlr_q;
    rx_cnt_d = rx_cnt_q;
    vd_d     = vd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    wptr_d   = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + PW'(1) : rptr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vlr_d    = vlr_i;
          vd_d     = vd_i;
          rx_cnt_d = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = (vlr_i == '0) ? StDrain : StCollect;
        end
      end
      StCollect: begin
        if (elem_in) begin
          rx_cnt_d = rx_cnt_q + VW'(1);
          if (rx_cnt_d == vlr_q) state_d = StDrain;
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase

    if (lost) ovf_d = 1'b1;

    // Finish as soon as draining would see an empty FIFO so done lands right after the last pop.
    if (state_d == StDrain && wptr_d == rptr_d) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      vlr_q    <= '0;
      rx_cnt_q <= '0;
      vd_q     <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vlr_q    <= vlr_d;
      rx_cnt_q <= rx_cnt_d;
      vd_q     <= vd_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {rx_cnt_q, push_data};
  end

  assign wr.we_o                   = !fifo_empty;
  assign wr.wreg_o                 = vd_q;
  assign {wr.widx_o, wr.wdata_o}   = mem_q[rptr_q[AW-1:0]];

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign id_o     = 8'(ID);

endmodule

// File: tb/tb_vec_wb_collector.sv
// Self-checking bench for vec_wb_collector: instruction table with a write scoreboard, plus
// hand sequences for reset, mid-flight reset and first-write latency.
module tb_vec_wb_collector;

  localparam int unsigned DW    = 32;
  localparam int unsigned MVLP  = 32;
  localparam int unsigned IDP   = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RB    = 5;
  localparam int unsigned VWP   = 6;

`ifdef VWB_MASK_ZERO_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct {
    int          vlr;
    int          vd;
    logic [31:0] mask;
    logic [31:0] dbase;
    int          stall;    // wr_ready_i low for cycles k < stall (k=0 is the start cycle)
    int          restart;  // element slot carrying an extra start pulse (0 = none)
    int          exp_wr;
    bit          exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [RB-1:0]  wreg;
    logic [VWP-1:0] idx;
    logic [DW-1:0]  data;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [VWP-1:0]   vlr_i;
  logic [RB-1:0]    vd_i;
  logic [DW+1:0]    result_i;
  logic             busy, done, overflow;
  logic [7:0]       id_o;

  vec_wb_collector_if #(.DATA_WIDTH(DW), .VW(VWP), .REG_BITS(RB)) wr_if ();

  vec_wb_collector #(
    .DATA_WIDTH(DW), .MVL(MVLP), .ID(IDP), .FIFO_DEPTH(DEPTH), .REG_BITS(RB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .vlr_i    (vlr_i),
    .vd_i     (vd_i),
    .result_i (result_i),
    .wr       (wr_if.master),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .id_o     (id_o)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  wr_cnt = 0;
  int  last_pop_edge = 0;
  int  done_edge = 0;
  bit  mon_en = 1'b0;
  wr_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: a write is taken at the coming posedge when we_o && wr_ready_i now.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_if.we_o && wr_if.wr_ready_i) begin
        wr_t got;
        got = {wr_if.wreg_o, wr_if.widx_o, wr_if.wdata_o};
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(got), 64'h0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_payload", 64'(got), 64'(e));
        end
        wr_cnt++;
        last_pop_edge = cyc + 1;
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int          done0, wr0, k, guard, exp_done_edge;
    bit          ovf_model;
    logic        m;
    logic [31:0] d;
    done0         = done_cnt;
    wr0           = wr_cnt;
    last_pop_edge = 0;
    ovf_model     = 1'b0;

    start             = 1'b1;
    vlr_i             = VWP'(v.vlr);
    vd_i              = RB'(v.vd);
    result_i          = '0;
    wr_if.wr_ready_i  = (v.stall <= 0);
    exp_done_edge     = cyc + 1;
    tick();
    start = 1'b0;
    if (v.vlr > 0) chk("busy_set", 64'(busy), 64'd1);

    for (int i = 0; i < v.vlr; i++) begin
      bit pushed;
      bit was_empty;
      k                = i + 1;
      wr_if.wr_ready_i = (k >= v.stall);
      m                = v.mask[i];
      d                = v.dbase + 32'(i);
      result_i         = {1'b1, m, d};
      if (k == v.restart) begin
        start = 1'b1;
        vlr_i = VWP'(2);
        vd_i  = '0;
      end
      pushed    = 1'b0;
      was_empty = (exp_q.size() == 0);
      if (m || ZF) begin
        if (!wr_if.wr_ready_i && exp_q.size() >= DEPTH) begin
          ovf_model = 1'b1;
        end else begin
          exp_q.push_back('{wreg: RB'(v.vd), idx: VWP'(i), data: (m ? d : 32'h0)});
          pushed = 1'b1;
        end
      end
      exp_done_edge = cyc + 1;
      tick();
      start = 1'b0;
      chk("ovf_elem", 64'(overflow), 64'(ovf_model));
      if (i == 0 && pushed && was_empty) chk("first_write_latency", 64'(wr_if.we_o), 64'd1);
    end

    result_i = '0;
    k        = v.vlr + 1;
    guard    = 0;
    while (done_cnt == done0 && guard < 400) begin
      wr_if.wr_ready_i = (k >= v.stall);
      tick();
      k++;
      guard++;
    end
    if (guard >= 400) chk("done_timeout", 64'(done_cnt - done0), 64'd1);

    // Results arriving after completion must be discarded.
    wr_if.wr_ready_i = 1'b1;
    result_i = {2'b11, 32'hDEAD_BEEF};
    tick();
    tick();
    result_i = '0;
    tick();

    if (last_pop_edge > exp_done_edge) exp_done_edge = last_pop_edge;
    chk("done_pulses", 64'(done_cnt - done0), 64'd1);
    chk("write_count", 64'(wr_cnt - wr0), 64'(v.exp_wr));
    chk("overflow_final", 64'(overflow), 64'(v.exp_ovf));
    chk("done_timing", 64'(done_edge), 64'(exp_done_edge));
    chk("busy_after", 64'(busy), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4,  3,  32'h0000_000D, 32'h10,  0,  0, (ZF ? 4 : 3), 1'b0};
    vecs[1] = '{0,  1,  32'h0,         32'h20,  0,  0, 0,            1'b0};
    vecs[2] = '{4,  7,  32'h0000_000F, 32'h30,  6,  0, 4,            1'b0};
    vecs[3] = '{6,  2,  32'h0000_003F, 32'h40,  10, 0, 4,            1'b1};
    vecs[4] = '{5,  9,  32'h0000_001F, 32'h50,  0,  3, 5,            1'b0};
    vecs[5] = '{8,  31, 32'h0000_00A5, 32'h60,  0,  0, (ZF ? 8 : 4), 1'b0};
    vecs[6] = '{8,  12, 32'h0,         32'h70,  0,  0, (ZF ? 8 : 0), 1'b0};
    vecs[7] = '{32, 20, 32'hFFFF_FFFF, 32'h100, 3,  0, 32,           1'b0};

    reset            = 1'b1;
    start            = 1'b0;
    vlr_i            = '0;
    vd_i             = '0;
    result_i         = '0;
    wr_if.wr_ready_i = 1'b0;
    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_we", 64'(wr_if.we_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("id", 64'(id_o), 64'(IDP));
    tick();

    for (int t = 0; t < 8; t++) run_vec(vecs[t]);

    // Reset after 2 of 8 elements with writes blocked; nothing may be written afterwards.
    start = 1'b1;
    vlr_i = VWP'(8);
    vd_i  = RB'(4);
    wr_if.wr_ready_i = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      result_i = {2'b11, 32'h80 + 32'(i)};
      tick();
    end
    chk("mid_we_before_rst", 64'(wr_if.we_o), 64'd1);
    chk("mid_busy_before_rst", 64'(busy), 64'd1);
    begin
      int wr0;
      wr0      = wr_cnt;
      reset    = 1'b1;
      result_i = {2'b11, 32'h82};
      tick();
      reset = 1'b0;
      chk("mid_we_after_rst", 64'(wr_if.we_o), 64'd0);
      chk("mid_busy_after_rst", 64'(busy), 64'd0);
      wr_if.wr_ready_i = 1'b1;
      for (int i = 3; i < 8; i++) begin
        result_i = {2'b11, 32'h80 + 32'(i)};
        tick();
      end
      result_i = '0;
      tick();
      chk("mid_no_writes", 64'(wr_cnt - wr0), 64'd0);
      chk("mid_we_idle", 64'(wr_if.we_o), 64'd0);
    end

    // Recovery after the abandoned instruction.
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
